// File: rtl/uncached_access_ctrl_if.sv
// uncached_access_ctrl_if: CPU, D-cache and bus signals around the uncached access controller
interface uncached_access_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        cache_req;
  logic        cache_we;
  logic [31:0] cache_addr;
  logic [31:0] cache_wdata;
  logic [3:0]  cache_wstrb;
  logic        cache_stall;
  logic [31:0] cache_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_rerr;
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_stall, cpu_rdata, cpu_err,
    output cache_req, cache_we, cache_addr, cache_wdata, cache_wstrb,
    input  cache_stall, cache_rdata,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_rerr
  );
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_stall, cpu_rdata, cpu_err,
    input  cache_req, cache_we, cache_addr, cache_wdata, cache_wstrb,
    output cache_stall, cache_rdata,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_gnt, bus_rvalid, bus_rdata, bus_rerr
  );
endinterface

// File: rtl/uncached_access_ctrl.sv
// uncached_access_ctrl: routes cacheable accesses to the D-cache and volatile ones to single-beat bus transactions
module uncached_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                    clk,
  input logic                    rst,
  uncached_access_ctrl_if.master b
);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, BUS_REQ, BUS_RESP, DONE, DRAIN} state_e;
  state_e      state_q;
  logic        orphan_q;
  logic [15:0] cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        vol;
  logic        idle;
  logic        done;
  assign vol  = b.cpu_addr[31:27] inside {5'b00001, 5'b00010, 5'b01000};
  assign idle = state_q == IDLE;
  assign done = state_q == DONE;
  assign b.cache_req   = idle & b.cpu_req & ~vol;
  assign b.cache_we    = b.cpu_we;
  assign b.cache_addr  = b.cpu_addr;
  assign b.cache_wdata = b.cpu_wdata;
  assign b.cache_wstrb = b.cpu_wstrb;
  assign b.cpu_stall   = idle ? b.cpu_req & (vol | b.cache_stall) : ~done;
  assign b.cpu_rdata   = done ? rdata_q : b.cache_rdata;
  assign b.cpu_err     = done & err_q;
  assign b.bus_req     = state_q == BUS_REQ;
  assign b.bus_we      = we_q;
  assign b.bus_addr    = addr_q;
  assign b.bus_wdata   = wdata_q;
  assign b.bus_wstrb   = wstrb_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      orphan_q <= 1'b0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else
      case (state_q)
        IDLE: begin
          if (b.bus_rvalid) orphan_q <= 1'b0;
          if (b.cpu_req && vol) begin
            we_q    <= b.cpu_we;
            addr_q  <= b.cpu_addr;
            wdata_q <= b.cpu_wdata;
            wstrb_q <= b.cpu_wstrb;
            // an orphan response landing this very cycle has already been retired
            state_q <= (orphan_q && !b.bus_rvalid) ? DRAIN : BUS_REQ;
          end
        end
        DRAIN:
          if (b.bus_rvalid) begin
            orphan_q <= 1'b0;
            state_q  <= BUS_REQ;
          end
        BUS_REQ:
          if (b.bus_gnt) begin
            cnt_q   <= '0;
            state_q <= BUS_RESP;
          end
        BUS_RESP: begin
          cnt_q <= cnt_q + 16'd1;
          if (b.bus_rvalid) begin
            rdata_q <= we_q ? 32'd0 : b.bus_rdata;
            err_q   <= b.bus_rerr;
            state_q <= DONE;
          end else if (cnt_q == TO_LAST) begin
            rdata_q  <= '0;
            err_q    <= 1'b1;
            orphan_q <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_uncached_access_ctrl.sv
// tb_uncached_access_ctrl: directed bench with a response scoreboard for uncached_access_ctrl
module tb_uncached_access_ctrl;
  localparam int TO = 4;
  typedef struct packed {logic [31:0] rdata; logic err;} resp_t;
  logic  clk = 1'b0;
  logic  rst;
  int    errors = 0;
  int    checks = 0;
  bit    orphan_m = 1'b0;
  resp_t sb[$];
  always #5 clk = ~clk;
  uncached_access_ctrl_if bi();
  uncached_access_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .b(bi));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pop_chk(input string tag);
    resp_t r;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb_empty: got 0 entries expected 1", tag);
    end
    if (sb.size() != 0) begin
      r = sb.pop_front();
      chk({tag, "_rdata"}, bi.cpu_rdata, r.rdata);
      chk1({tag, "_err"}, bi.cpu_err, r.err);
    end
  endtask
  task automatic cache_access(input logic [31:0] addr, input logic stall, input logic [31:0] crd);
    resp_t r;
    bi.cpu_req = 1'b1; bi.cpu_we = 1'b0; bi.cpu_addr = addr;
    bi.cache_stall = stall; bi.cache_rdata = crd;
    @(negedge clk);
    chk1("c_cache_req", bi.cache_req, 1'b1);
    chk("c_cache_addr", bi.cache_addr, addr);
    chk1("c_stall", bi.cpu_stall, stall);
    chk1("c_bus_req", bi.bus_req, 1'b0);
    if (!stall) begin
      r.rdata = crd; r.err = 1'b0;
      sb.push_back(r);
      pop_chk("c");
    end
    tick;
    bi.cpu_req = 1'b0; bi.cache_stall = 1'b0;
  endtask
  task automatic vol_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int gd, input int rd,
                            input logic [31:0] rdata, input logic rerr, input int dd);
    resp_t r;
    int n;
    bi.cpu_req = 1'b1; bi.cpu_we = we; bi.cpu_addr = addr; bi.cpu_wdata = wdata; bi.cpu_wstrb = wstrb;
    bi.bus_gnt = 1'b0; bi.bus_rvalid = 1'b0;
    r.rdata = (rd < TO && !we) ? rdata : 32'd0;
    r.err   = (rd < TO) ? rerr : 1'b1;
    sb.push_back(r);
    @(negedge clk);
    chk1("t0_stall", bi.cpu_stall, 1'b1);
    chk1("t0_cache_req", bi.cache_req, 1'b0);
    chk1("t0_bus_req", bi.bus_req, 1'b0);
    tick;
    if (orphan_m) begin
      for (int i = 0; i <= dd; i++) begin
        bi.bus_rvalid = (i == dd); bi.bus_rdata = 32'hDEAD_BEEF; bi.bus_rerr = 1'b1;
        @(negedge clk);
        chk1("drain_bus_req", bi.bus_req, 1'b0);
        chk1("drain_stall", bi.cpu_stall, 1'b1);
        tick;
      end
      bi.bus_rvalid = 1'b0;
      orphan_m = 1'b0;
    end
    for (int i = 0; i <= gd; i++) begin
      bi.bus_gnt = (i == gd);
      @(negedge clk);
      chk1("req_bus_req", bi.bus_req, 1'b1);
      chk1("req_stall", bi.cpu_stall, 1'b1);
      if (i == 0) begin
        chk1("req_we", bi.bus_we, we);
        chk("req_addr", bi.bus_addr, addr);
        chk("req_wdata", bi.bus_wdata, wdata);
        chk("req_wstrb", {28'd0, bi.bus_wstrb}, {28'd0, wstrb});
      end
      tick;
    end
    bi.bus_gnt = 1'b0;
    n = (rd < TO) ? rd + 1 : TO;
    for (int i = 0; i < n; i++) begin
      bi.bus_rvalid = (i == rd); bi.bus_rdata = rdata; bi.bus_rerr = rerr;
      @(negedge clk);
      chk1("resp_bus_req", bi.bus_req, 1'b0);
      chk1("resp_stall", bi.cpu_stall, 1'b1);
      tick;
    end
    bi.bus_rvalid = 1'b0; bi.bus_rerr = 1'b0;
    if (rd >= TO) orphan_m = 1'b1;
    @(negedge clk);
    chk1("done_stall", bi.cpu_stall, 1'b0);
    chk1("done_cache_req", bi.cache_req, 1'b0);
    pop_chk("done");
    tick;
    bi.cpu_req = 1'b0;
    @(negedge clk);
    chk1("idle_stall", bi.cpu_stall, 1'b0);
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    bi.cpu_req = 1'b0; bi.cpu_we = 1'b0; bi.cpu_addr = '0; bi.cpu_wdata = '0; bi.cpu_wstrb = '0;
    bi.cache_stall = 1'b0; bi.cache_rdata = 32'h1357_9BDF;
    bi.bus_gnt = 1'b0; bi.bus_rvalid = 1'b0; bi.bus_rdata = '0; bi.bus_rerr = 1'b0;
    #1;
    chk1("rst_bus_req", bi.bus_req, 1'b0);
    chk1("rst_stall", bi.cpu_stall, 1'b0);
    chk1("rst_err", bi.cpu_err, 1'b0);
    chk("rst_rdata", bi.cpu_rdata, 32'h1357_9BDF);
    tick; tick;
    rst = 1'b0;
    tick;
    cache_access(32'h0001_0000, 1'b0, 32'hC0FF_EE01);
    cache_access(32'h0001_0000, 1'b1, 32'hC0FF_EE02);
    cache_access(32'h0001_0000, 1'b0, 32'hC0FF_EE03);
    @(negedge clk);
    chk1("noreq_cache_req", bi.cache_req, 1'b0);
    chk1("noreq_stall", bi.cpu_stall, 1'b0);
    tick;
    vol_access(1'b0, 32'h1000_0004, 32'd0, 4'hF, 0, 0, 32'hA5A5_1234, 1'b0, 0);
    vol_access(1'b1, 32'h4000_0000, 32'hCAFE_BABE, 4'b0011, 3, 0, 32'h1111_2222, 1'b1, 0);
    vol_access(1'b0, 32'h0800_0000, 32'd0, 4'hF, 0, TO, 32'h7777_7777, 1'b0, 0);
    chk1("to_orphan", dut.orphan_q, 1'b1);
    vol_access(1'b0, 32'h0800_0008, 32'd0, 4'hF, 0, 1, 32'h2468_ACE0, 1'b0, 2);
    chk1("drained_orphan", dut.orphan_q, 1'b0);
    vol_access(1'b0, 32'h1000_0010, 32'd0, 4'hF, 1, TO - 1, 32'h5A5A_0F0F, 1'b1, 0);
    chk1("tie_orphan", dut.orphan_q, 1'b0);
    bi.cpu_req = 1'b1; bi.cpu_we = 1'b0; bi.cpu_addr = 32'h0800_0010;
    tick;
    bi.bus_gnt = 1'b1;
    tick;
    bi.bus_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk1("arst_bus_req", bi.bus_req, 1'b0);
    chk1("arst_orphan", dut.orphan_q, 1'b0);
    chk("arst_state", 32'(dut.state_q), 32'd0);
    bi.cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick;
    vol_access(1'b0, 32'h1000_0020, 32'd0, 4'hF, 0, 0, 32'h0BAD_F00D, 1'b0, 0);
    cache_access(32'h2000_0040, 1'b0, 32'h3141_5926);
    vol_access(1'b1, 32'h4000_0100, 32'h1234_5678, 4'b1100, 1, 2, 32'hFFFF_FFFF, 1'b0, 0);
    chk("sb_left", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
